// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock blocks: mode encoding, display blank
// bit positions and small helpers used by the mode controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_e;

  localparam int unsigned BLANK_HR  = 2;
  localparam int unsigned BLANK_MIN = 1;
  localparam int unsigned BLANK_SEC = 0;

  // Mode order cycled by the mode button.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    n = RUN;
    case (m)
      RUN:     n = SET_HR;
      SET_HR:  n = SET_MIN;
      SET_MIN: n = SET_SEC;
      SET_SEC: n = RUN;
      default: n = RUN;
    endcase
    return n;
  endfunction

  // One-hot blank position of the field adjusted in a given mode (zero in RUN).
  function automatic logic [2:0] blank_mask(input mode_e m);
    logic [2:0] b;
    b = '0;
    case (m)
      SET_HR:  b[BLANK_HR]  = 1'b1;
      SET_MIN: b[BLANK_MIN] = 1'b1;
      SET_SEC: b[BLANK_SEC] = 1'b1;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button/carry inputs and strobe/blank outputs between the clock controller
// and its surroundings; the controller takes the slave view.
interface clock_mode_ctrl_if;

  logic                 en;
  logic                 btn_mode;
  logic                 btn_inc;
  logic                 sec_max;
  logic                 min_max;
  clock_pkg::mode_e     mode;
  logic                 inc_sec;
  logic                 inc_min;
  logic                 inc_hr;
  logic                 clr_sec;
  logic [2:0]           blank;

  modport master (
    output en, btn_mode, btn_inc, sec_max, min_max,
    input  mode, inc_sec, inc_min, inc_hr, clr_sec, blank
  );

  modport slave (
    input  en, btn_mode, btn_inc, sec_max, min_max,
    output mode, inc_sec, inc_min, inc_hr, clr_sec, blank
  );

endinterface

// File: rtl/tick_gen.sv
// Modulo-DIV cycle counter with enable and synchronous clear; o_wrap is high
// during the enabled cycle in which the count sits at DIV-1.
module tick_gen #(
  parameter int unsigned DIV = 4,
  parameter int unsigned W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_at_top;

  assign w_at_top = (r_cnt == W'(DIV - 1));
  assign o_wrap   = i_en && !i_clr && w_at_top;

  // NOTE: reset is sampled on the clock edge (synchronous), so rst sits in
  // the body, not in the sensitivity list; sequential state always uses <=.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_top ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN/SET mode sequencer for the clock counters: 1 Hz advance with carry
// qualification, button-driven field adjust, and blink blanking of that field.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned TW        = 27,
  parameter int unsigned BW        = 25
) (
  input  logic                clk,
  input  logic                rst,
  clock_mode_ctrl_if.slave    bus
);

  mode_e      r_mode;
  logic       r_inc_sec;
  logic       r_inc_min;
  logic       r_inc_hr;
  logic       r_clr_sec;
  logic       r_phase;
  logic [2:0] r_blank;

  logic w_run;
  logic w_tick;
  logic w_blink_wrap;
  logic w_inc_ok;
  logic w_blink_clr;

  assign w_run       = (r_mode == RUN);
  // A mode press in the same cycle swallows the adjust press.
  assign w_inc_ok    = bus.btn_inc && !bus.btn_mode && !w_run;
  assign w_blink_clr = w_run || bus.btn_mode || w_inc_ok;

  tick_gen #(
    .DIV (TICK_DIV),
    .W   (TW)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run && bus.en),
    .i_clr  (!w_run),
    .o_wrap (w_tick)
  );

  tick_gen #(
    .DIV (BLINK_DIV),
    .W   (BW)
  ) u_blink_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (!w_run),
    .i_clr  (w_blink_clr),
    .o_wrap (w_blink_wrap)
  );

  // Mode FSM with registered strobes. A tick coinciding with a mode press is
  // dropped so no time-advance strobe ever appears while in a SET mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode    <= RUN;
      r_inc_sec <= 1'b0;
      r_inc_min <= 1'b0;
      r_inc_hr  <= 1'b0;
      r_clr_sec <= 1'b0;
    end else begin
      r_inc_sec <= 1'b0;
      r_inc_min <= 1'b0;
      r_inc_hr  <= 1'b0;
      r_clr_sec <= 1'b0;
      if (bus.btn_mode) begin
        r_mode <= next_mode(r_mode);
      end else begin
        case (r_mode)
          RUN: begin
            if (w_tick) begin
              r_inc_sec <= 1'b1;
              r_inc_min <= bus.sec_max;
              r_inc_hr  <= bus.sec_max && bus.min_max;
            end
          end
          SET_HR:  r_inc_hr  <= bus.btn_inc;
          SET_MIN: r_inc_min <= bus.btn_inc;
          SET_SEC: r_clr_sec <= bus.btn_inc;
          default: r_mode    <= RUN;
        endcase
      end
    end
  end

  // Blink phase restarts lit on every mode change and every accepted adjust.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase <= 1'b0;
    end else if (w_blink_clr) begin
      r_phase <= 1'b0;
    end else if (w_blink_wrap) begin
      r_phase <= ~r_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blank <= '0;
    end else begin
      r_blank <= r_phase ? blank_mask(r_mode) : 3'b000;
    end
  end

  assign bus.mode    = r_mode;
  assign bus.inc_sec = r_inc_sec;
  assign bus.inc_min = r_inc_min;
  assign bus.inc_hr  = r_inc_hr;
  assign bus.clr_sec = r_clr_sec;
  assign bus.blank   = r_blank;

endmodule
